// File: rtl/serial_adder_pkg.sv
// Shared types for the digit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Digit counter width; a single-digit configuration still keeps one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell; purely combinational, no state, no flow control.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract, DIGIT bits per cycle; result valid WIDTH/DIGIT+1 cycles after accept.
// One operation in flight: ready_o only in IDLE, result held in DONE until ready_i.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o,
  output logic             ovf_o
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, c_q, ovf_q;
  logic [DIGIT:0]   cy;
  logic [DIGIT-1:0] dig_s;
  logic             last_dig;

  assign last_dig = (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (valid_i)  state_nxt = ST_RUN;
      ST_RUN:  if (last_dig) state_nxt = ST_DONE;
      ST_DONE: if (ready_i)  state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == ST_IDLE);
    valid_o = (state == ST_DONE);
  end

  // Operands sit in shift registers so the active digit is always the low DIGIT bits.
  assign cy[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fulladder u_fa (
      .a  (a_q[i]),
      .b  (b_q[i]),
      .ci (cy[i]),
      .s  (dig_s[i]),
      .co (cy[i+1])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (valid_i && ready_o) begin
      a_q     <= a_i;
      b_q     <= sub_i ? ~b_i : b_i;
      carry_q <= sub_i | c_i;
      cnt_q   <= '0;
    end else if (state == ST_RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      // New digit enters at the top; after NDIG shifts digit 0 lands at bit 0.
      sum_q   <= WIDTH'({dig_s, sum_q} >> DIGIT);
      carry_q <= cy[DIGIT];
      if (last_dig) begin
        c_q   <= cy[DIGIT];
        ovf_q <= cy[DIGIT] ^ cy[DIGIT-1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign sum_o = sum_q;
  assign c_o   = c_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench: three adder configurations (DIGIT 1/4/16) on shared operands.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_s, b_s;
  logic        c_s, sub_s;
  logic [2:0]  vld, rdy;
  logic [2:0]  rdy_o_w, vld_o_w, co_w, ovf_w;
  logic [15:0] sum_w [3];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(1)) u_dut_d1 (
    .clk_i(clk), .rst_i(rst), .valid_i(vld[0]), .ready_o(rdy_o_w[0]),
    .a_i(a_s), .b_i(b_s), .c_i(c_s), .sub_i(sub_s),
    .valid_o(vld_o_w[0]), .ready_i(rdy[0]), .sum_o(sum_w[0]), .c_o(co_w[0]), .ovf_o(ovf_w[0])
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut_d4 (
    .clk_i(clk), .rst_i(rst), .valid_i(vld[1]), .ready_o(rdy_o_w[1]),
    .a_i(a_s), .b_i(b_s), .c_i(c_s), .sub_i(sub_s),
    .valid_o(vld_o_w[1]), .ready_i(rdy[1]), .sum_o(sum_w[1]), .c_o(co_w[1]), .ovf_o(ovf_w[1])
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut_d16 (
    .clk_i(clk), .rst_i(rst), .valid_i(vld[2]), .ready_o(rdy_o_w[2]),
    .a_i(a_s), .b_i(b_s), .c_i(c_s), .sub_i(sub_s),
    .valid_o(vld_o_w[2]), .ready_i(rdy[2]), .sum_o(sum_w[2]), .c_o(co_w[2]), .ovf_o(ovf_w[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation to all three instances; operands are scrambled after accept.
  task automatic run_all(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s, input logic [15:0] es,
                         input logic ec, input logic eo);
    int          el [3] = '{17, 5, 2};
    int          dg [3] = '{1, 4, 16};
    int          lat [3];
    logic [15:0] rs [3];
    logic        rc [3];
    logic        ro [3];
    @(negedge clk);
    a_s = a; b_s = b; c_s = c; sub_s = s;
    vld = 3'b111; rdy = 3'b111;
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0; rs[d] = 'x; rc[d] = 1'bx; ro[d] = 1'bx;
    end
    @(negedge clk);
    vld = 3'b000;
    a_s = 16'hDEAD; b_s = 16'hBEEF; c_s = ~c; sub_s = ~s;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (lat[d] == 0 && vld_o_w[d]) begin
          lat[d] = cyc; rs[d] = sum_w[d]; rc[d] = co_w[d]; ro[d] = ovf_w[d];
        end
      end
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s/d%0d sum", tag, dg[d]), 32'(rs[d]), 32'(es));
      chk($sformatf("%s/d%0d c_o", tag, dg[d]), 32'(rc[d]), 32'(ec));
      chk($sformatf("%s/d%0d ovf", tag, dg[d]), 32'(ro[d]), 32'(eo));
      chk($sformatf("%s/d%0d lat", tag, dg[d]), 32'(lat[d]), 32'(el[d]));
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1; vld = 3'b000; rdy = 3'b000;
    a_s = '0; b_s = '0; c_s = 1'b0; sub_s = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst/%0d ready", d), 32'(rdy_o_w[d]), 32'd1);
      chk($sformatf("rst/%0d valid", d), 32'(vld_o_w[d]), 32'd0);
      chk($sformatf("rst/%0d sum", d), 32'(sum_w[d]), 32'd0);
      chk($sformatf("rst/%0d c_o", d), 32'(co_w[d]), 32'd0);
      chk($sformatf("rst/%0d ovf", d), 32'(ovf_w[d]), 32'd0);
    end

    run_all("add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_all("add_7fff_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_all("add_cin",     16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0);
    run_all("sub_5_7",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_all("sub_8000_1",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_all("add_neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_all("sub_equal",   16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_all("add_a5_5a",   16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_all("sub_cin_ign", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0);

    // Backpressure: result held in DONE while ready_i stays low, new requests ignored.
    @(negedge clk);
    a_s = 16'h7FFF; b_s = 16'h0001; c_s = 1'b0; sub_s = 1'b0;
    vld[1] = 1'b1; rdy[1] = 1'b0;
    seen = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      a_s = 16'h0F0F + 16'(cyc); b_s = 16'h1111;
      if (vld_o_w[1]) begin
        seen = cyc;
        break;
      end
    end
    chk("hold/lat", 32'(seen), 32'd5);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold/%0d sum", i), 32'(sum_w[1]), 32'h8000);
      chk($sformatf("hold/%0d c_o", i), 32'(co_w[1]), 32'd0);
      chk($sformatf("hold/%0d ovf", i), 32'(ovf_w[1]), 32'd1);
      chk($sformatf("hold/%0d valid", i), 32'(vld_o_w[1]), 32'd1);
      chk($sformatf("hold/%0d ready", i), 32'(rdy_o_w[1]), 32'd0);
      a_s = 16'h0001 << (i % 16);
      @(negedge clk);
    end
    rdy[1] = 1'b1; vld[1] = 1'b0;
    @(negedge clk);
    chk("hold/release valid", 32'(vld_o_w[1]), 32'd0);
    chk("hold/release ready", 32'(rdy_o_w[1]), 32'd1);

    // Reset while digit 2 is being added: no result may appear afterwards.
    a_s = 16'hFFFF; b_s = 16'hFFFF; c_s = 1'b0; sub_s = 1'b0;
    vld[1] = 1'b1;
    @(negedge clk);
    vld[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort/ready", 32'(rdy_o_w[1]), 32'd1);
    chk("abort/valid", 32'(vld_o_w[1]), 32'd0);
    chk("abort/sum", 32'(sum_w[1]), 32'd0);
    chk("abort/c_o", 32'(co_w[1]), 32'd0);
    chk("abort/ovf", 32'(ovf_w[1]), 32'd0);
    seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (vld_o_w[1]) seen++;
    end
    chk("abort/no_result", 32'(seen), 32'd0);
    chk("abort/ready_after", 32'(rdy_o_w[1]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
